apb_slave_regfile: RTL and testbench
====================================

APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: PADDR width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: PWDATA/PRDATA width.
REQ-003 SHALL have parameter NUM_REGS, default 16: register count, power of two, 4..256.
REQ-004 SHALL have parameter WAIT_CYCLES, default 1: PREADY-low cycles per access, 0..15.
REQ-005 SHALL have port HCLK, input, 1: clock; all logic on rising edge.
REQ-006 SHALL have port HRESETn, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port PSEL, input, 1: slave select.
REQ-008 SHALL have port PENABLE, input, 1: access phase.
REQ-009 SHALL have port PADDR, input, ADDR_WIDTH: byte address.
REQ-010 SHALL have port PWRITE, input, 1: 1 = write, 0 = read.
REQ-011 SHALL have port PWDATA, input, DATA_WIDTH: write data.
REQ-012 SHALL have port PRDATA, output, DATA_WIDTH: read data.
REQ-013 SHALL have port PREADY, output, 1: transfer completes this cycle.
REQ-014 SHALL have port PSLVERR, output, 1: error response, valid only when PREADY=1.

Function
REQ-015 SHALL implement FSM states ST_IDLE, ST_WAIT, ST_READY.
REQ-016 SHALL, in ST_IDLE with PSEL=1 and PENABLE=0 (setup), latch PADDR/PWRITE/PWDATA, load wait counter with WAIT_CYCLES, and go to ST_WAIT (WAIT_CYCLES>0) or ST_READY (WAIT_CYCLES=0).
REQ-017 SHALL decrement the counter each cycle in ST_WAIT with PSEL=PENABLE=1, and go to ST_READY when it reaches 1, giving exactly WAIT_CYCLES PREADY-low access cycles.
REQ-018 SHALL drive PREADY=1 only in ST_READY with PSEL=PENABLE=1; otherwise 0.
REQ-019 SHALL return from ST_READY to ST_IDLE on the next edge; the following cycle may be a new setup (back-to-back).
REQ-020 SHALL abort to ST_IDLE with no register update if PSEL or PENABLE drops in ST_WAIT/ST_READY before completion.
REQ-021 SHALL decode index = latched PADDR[log2(NUM_REGS)+1:2]; error if PADDR[1:0]!=0 or PADDR >= NUM_REGS*4.
REQ-022 SHALL treat reg 0 as read-only ID 32'hA9B0_0001; write to it is an error.
REQ-023 SHALL treat reg 1 as read-only transfer counter: low 16 bits count error-free completed transfers, wrap 16'hFFFF->0, upper bits 0; write to it is an error.
REQ-024 SHALL drive PSLVERR=1 with PREADY for error transfers, else 0.
REQ-025 SHALL commit writes to regs 2..NUM_REGS-1 on the PREADY=1 edge only when PSLVERR=0.
REQ-026 SHALL drive PRDATA = selected register when PREADY=1, PWRITE=0, PSLVERR=0; otherwise 0.
REQ-027 SHALL, when reading reg 1, return the pre-increment value; the increment occurs on the same edge.

Reset
REQ-028 SHALL, on HRESETn=0, immediately force ST_IDLE, wait counter 0, regs 2..NUM_REGS-1 to 0, transfer counter 0, PREADY=0, PSLVERR=0, PRDATA=0.
REQ-029 SHALL discard any in-flight transfer on reset without a register update.

Structure
REQ-030 SHALL place the FSM state enum, ID constant, and reg-0/reg-1 index constants in shared package apb_pkg.
REQ-031 SHALL be a single module; no sub-module.

Verification
REQ-032 SHALL verify write/read: WAIT_CYCLES=2, write 32'h1234_5678 to 0x08, then read 0x08 -> PREADY low 2 cycles each, read returns 32'h1234_5678, PSLVERR=0, reg 1 reads 2.
REQ-033 SHALL verify read-only regs: read 0x00 -> 32'hA9B0_0001; write 0x00 or 0x04 -> PSLVERR=1, values unchanged, counter not incremented.
REQ-034 SHALL verify decode errors: write 0x40 or 0x09 (NUM_REGS=16) -> PSLVERR=1, PRDATA=0, no register changes.
REQ-035 SHALL verify abort: PSEL dropped in second wait cycle of a write to 0x0C -> FSM ST_IDLE, reg 3 unchanged, no PREADY pulse.
REQ-036 SHALL verify reset mid-wait: HRESETn low during ST_WAIT -> PREADY=0 at once, reg 2 reads 0 after release.
REQ-037 SHALL verify zero-wait back-to-back: WAIT_CYCLES=0, writes to 0x08 and 0x0C in consecutive setup/access pairs -> PREADY=1 in each access cycle, both committed, counter=2.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the APB slave register file.
// Holds the FSM state encoding, the read-only ID value and the indices of
// the two read-only registers (ID and transfer counter).
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  localparam logic [31:0] REG_ID_VALUE = 32'hA9B0_0001;
  localparam int          REG_ID_IDX   = 0;
  localparam int          REG_CNT_IDX  = 1;

endpackage

// File: rtl/apb_slave_regfile.sv
// APB slave register file with a fixed number of wait states per access.
//   reg 0          : read-only ID
//   reg 1          : read-only count of error-free completed transfers (16 bit)
//   reg 2..N-1     : read/write storage
// Ports:
//   HCLK, HRESETn  : clock (rising edge), async active-low reset
//   PSEL, PENABLE  : APB select / access phase
//   PADDR, PWRITE  : byte address, direction (1 = write)
//   PWDATA         : write data
//   PRDATA         : read data, nonzero only on an error-free read completion
//   PREADY         : transfer completes this cycle
//   PSLVERR        : error response, qualified by PREADY
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int IDXW = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);

  state_t state, state_nxt;
  logic [3:0] wcnt, wcnt_nxt;
  logic       load;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  // Entries 0 and 1 are never written; their values come from the ID
  // constant and the transfer counter instead.
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
  logic [15:0]                         xfer_cnt;

  logic            access, setup, err;
  logic [IDXW-1:0] idx;
  logic [DATA_WIDTH-1:0] rd_sel;

  assign access = PSEL && PENABLE;
  assign setup  = PSEL && !PENABLE;
  assign idx    = addr_q[IDXW+1:2];

  // Decode is done on the latched address so the response is stable for
  // the whole access phase regardless of what the master does to PADDR.
  assign err = (addr_q[1:0] != 2'b00) || (addr_q >= ADDR_LIMIT) ||
               (wr_q && (idx == IDXW'(REG_ID_IDX) || idx == IDXW'(REG_CNT_IDX)));

  always_comb begin
    rd_sel = regs[idx];
    if (idx == IDXW'(REG_ID_IDX))  rd_sel = DATA_WIDTH'(REG_ID_VALUE);
    if (idx == IDXW'(REG_CNT_IDX)) rd_sel = DATA_WIDTH'(xfer_cnt);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    load      = 1'b0;
    PREADY    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (setup) begin
          load      = 1'b1;
          wcnt_nxt  = 4'(WAIT_CYCLES);
          state_nxt = (WAIT_CYCLES == 0) ? ST_READY : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Leaving on a count of 1 gives exactly WAIT_CYCLES low access cycles.
        if (access) begin
          wcnt_nxt = wcnt - 4'd1;
          if (wcnt <= 4'd1) state_nxt = ST_READY;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_READY: begin
        // A dropped PSEL/PENABLE here is an abort: no PREADY, no commit.
        PREADY    = access;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign PSLVERR = PREADY && err;
  assign PRDATA  = (PREADY && !wr_q && !err) ? rd_sel : '0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q   <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      regs     <= '0;
      xfer_cnt <= '0;
    end else begin
      if (load) begin
        addr_q  <= PADDR;
        wr_q    <= PWRITE;
        wdata_q <= PWDATA;
      end
      // Reads of reg 1 see the old count; the increment lands on this edge.
      if (PREADY && !err) begin
        xfer_cnt <= xfer_cnt + 16'd1;
        if (wr_q) regs[idx] <= wdata_q;
      end
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: instance 0 has two wait states, instance 1
// has none. Directed table plus hand sequences, then random traffic against
// a simple array/counter model of the register map.
module tb_apb_slave_regfile;
  import apb_pkg::*;

  localparam int W0 = 2;
  localparam int W1 = 0;

  logic        clk;
  logic        rst_n  [2];
  logic        psel   [2];
  logic        pen    [2];
  logic        pwr    [2];
  logic [31:0] paddr  [2];
  logic [31:0] pwdata [2];
  logic [31:0] prdata [2];
  logic        pready [2];
  logic        pslverr[2];

  int total = 0;
  int bad   = 0;

  // reference model: plain storage + counter per instance
  logic [31:0] mem [2][16];
  logic [15:0] mcnt[2];

  apb_slave_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_CYCLES(W0)) u_d0 (
    .HCLK(clk), .HRESETn(rst_n[0]), .PSEL(psel[0]), .PENABLE(pen[0]), .PADDR(paddr[0]),
    .PWRITE(pwr[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]));

  apb_slave_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_CYCLES(W1)) u_d1 (
    .HCLK(clk), .HRESETn(rst_n[1]), .PSEL(psel[1]), .PENABLE(pen[1]), .PADDR(paddr[1]),
    .PWRITE(pwr[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset(input int d);
    for (int i = 0; i < 16; i++) mem[d][i] = '0;
    mcnt[d] = '0;
  endtask

  task automatic model(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd,
                       output logic [31:0] erd, output logic eer);
    eer = (a % 4 != 0) || (a >= 64) || (w && a < 8);
    erd = '0;
    if (!eer) begin
      if (!w) erd = (a == 0) ? 32'hA9B0_0001 : (a == 4) ? {16'h0, mcnt[d]} : mem[d][a/4];
      if (w) mem[d][a/4] = wd;
      mcnt[d] = mcnt[d] + 16'd1;
    end
  endtask

  task automatic idle(input int d);
    @(negedge clk);
    psel[d] = 1'b0;
    pen[d]  = 1'b0;
  endtask

  // One APB transfer. abort_at >= 0 drops PSEL/PENABLE at that access cycle.
  // Returns with the bus still driven so a following call is back-to-back.
  task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd,
                      input int abort_at, output logic [31:0] rd, output logic er,
                      output int low, output logic done);
    bit stop;
    @(negedge clk);
    psel[d] = 1'b1; pen[d] = 1'b0; paddr[d] = a; pwr[d] = w; pwdata[d] = wd;
    done = 1'b0; low = 0; rd = '0; er = 1'b0; stop = 0;
    for (int c = 0; c < 20 && !stop; c++) begin
      @(negedge clk);
      if (c == abort_at) begin
        psel[d] = 1'b0; pen[d] = 1'b0;
        #1;
        done = pready[d];
        stop = 1;
      end else begin
        pen[d] = 1'b1;
        #1;
        if (pready[d]) begin
          rd = prdata[d]; er = pslverr[d]; done = 1'b1; stop = 1;
        end else begin
          low++;
        end
      end
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [31:0] rd, erd, a, wd;
    logic er, eer, done, w;
    int low, ab, waits;

    tbl[0]  = '{32'h08, 1'b1, 32'h1234_5678, 1'b0, 32'h0};
    tbl[1]  = '{32'h08, 1'b0, 32'h0,         1'b0, 32'h1234_5678};
    tbl[2]  = '{32'h04, 1'b0, 32'h0,         1'b0, 32'h2};
    tbl[3]  = '{32'h00, 1'b0, 32'h0,         1'b0, 32'hA9B0_0001};
    tbl[4]  = '{32'h00, 1'b1, 32'h55AA_55AA, 1'b1, 32'h0};
    tbl[5]  = '{32'h04, 1'b1, 32'h0000_0001, 1'b1, 32'h0};
    tbl[6]  = '{32'h04, 1'b0, 32'h0,         1'b0, 32'h4};
    tbl[7]  = '{32'h00, 1'b0, 32'h0,         1'b0, 32'hA9B0_0001};
    tbl[8]  = '{32'h40, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0};
    tbl[9]  = '{32'h09, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0};
    tbl[10] = '{32'h40, 1'b0, 32'h0,         1'b1, 32'h0};
    tbl[11] = '{32'h08, 1'b0, 32'h0,         1'b0, 32'h1234_5678};
    tbl[12] = '{32'h04, 1'b0, 32'h0,         1'b0, 32'h7};

    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; psel[d] = 1'b0; pen[d] = 1'b0; pwr[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0;
      model_reset(d);
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_pready", {31'b0, pready[d]}, 32'h0);
      chk("reset_pslverr", {31'b0, pslverr[d]}, 32'h0);
      chk("reset_prdata", prdata[d], 32'h0);
    end
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    // directed table on the two-wait-state instance
    for (int i = 0; i < 13; i++) begin
      xfer(0, tbl[i].addr, tbl[i].wr, tbl[i].data, -1, rd, er, low, done);
      model(0, tbl[i].addr, tbl[i].wr, tbl[i].data, erd, eer);
      chk($sformatf("tbl%0d_ready", i), {31'b0, done}, 32'h1);
      chk($sformatf("tbl%0d_waits", i), low, W0);
      chk($sformatf("tbl%0d_err", i), {31'b0, er}, {31'b0, tbl[i].exp_err});
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
    end
    idle(0);

    // abort: PSEL drops in the second wait cycle of a write to reg 3
    xfer(0, 32'h0C, 1'b1, 32'hCAFE_F00D, 1, rd, er, low, done);
    chk("abort_no_ready", {31'b0, done}, 32'h0);
    @(negedge clk); #1;
    chk("abort_idle", {31'b0, u_d0.state == ST_IDLE}, 32'h1);
    chk("abort_pready_low", {31'b0, pready[0]}, 32'h0);
    xfer(0, 32'h0C, 1'b0, 32'h0, -1, rd, er, low, done);
    model(0, 32'h0C, 1'b0, 32'h0, erd, eer);
    chk("abort_reg3", rd, 32'h0);
    chk("abort_reg3_waits", low, W0);
    idle(0);

    // reset while waiting: PREADY low at once, storage cleared
    @(negedge clk);
    psel[0] = 1'b1; pen[0] = 1'b0; paddr[0] = 32'h08; pwr[0] = 1'b1; pwdata[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    pen[0] = 1'b1;
    #1 rst_n[0] = 1'b0;
    #1;
    chk("rstwait_pready", {31'b0, pready[0]}, 32'h0);
    chk("rstwait_pslverr", {31'b0, pslverr[0]}, 32'h0);
    chk("rstwait_idle", {31'b0, u_d0.state == ST_IDLE}, 32'h1);
    idle(0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    model_reset(0);
    xfer(0, 32'h08, 1'b0, 32'h0, -1, rd, er, low, done);
    model(0, 32'h08, 1'b0, 32'h0, erd, eer);
    chk("rstwait_reg2", rd, 32'h0);
    xfer(0, 32'h04, 1'b0, 32'h0, -1, rd, er, low, done);
    model(0, 32'h04, 1'b0, 32'h0, erd, eer);
    chk("rstwait_cnt", rd, 32'h1);
    idle(0);

    // zero-wait back-to-back writes
    xfer(1, 32'h08, 1'b1, 32'h1111_2222, -1, rd, er, low, done);
    model(1, 32'h08, 1'b1, 32'h1111_2222, erd, eer);
    chk("b2b_w0_ready", {31'b0, done}, 32'h1);
    chk("b2b_w0_waits", low, 0);
    xfer(1, 32'h0C, 1'b1, 32'h3333_4444, -1, rd, er, low, done);
    model(1, 32'h0C, 1'b1, 32'h3333_4444, erd, eer);
    chk("b2b_w1_ready", {31'b0, done}, 32'h1);
    chk("b2b_w1_waits", low, 0);
    idle(1);
    xfer(1, 32'h04, 1'b0, 32'h0, -1, rd, er, low, done);
    model(1, 32'h04, 1'b0, 32'h0, erd, eer);
    chk("b2b_cnt", rd, 32'h2);
    xfer(1, 32'h08, 1'b0, 32'h0, -1, rd, er, low, done);
    model(1, 32'h08, 1'b0, 32'h0, erd, eer);
    chk("b2b_reg2", rd, 32'h1111_2222);
    xfer(1, 32'h0C, 1'b0, 32'h0, -1, rd, er, low, done);
    model(1, 32'h0C, 1'b0, 32'h0, erd, eer);
    chk("b2b_reg3", rd, 32'h3333_4444);
    idle(1);

    // random traffic against the model on both instances
    for (int d = 0; d < 2; d++) begin
      waits = (d == 0) ? W0 : W1;
      for (int n = 0; n < 200; n++) begin
        case ($urandom_range(0, 9))
          7:       a = $urandom_range(0, 15) * 4 + $urandom_range(1, 3);
          8:       a = 64 + $urandom_range(0, 255) * 4;
          9:       a = $urandom;
          default: a = $urandom_range(0, 15) * 4;
        endcase
        w  = $urandom_range(0, 1);
        wd = $urandom;
        ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, waits) : -1;
        xfer(d, a, w, wd, ab, rd, er, low, done);
        if (ab >= 0) begin
          chk($sformatf("rnd%0d_%0d_abort", d, n), {31'b0, done}, 32'h0);
        end else begin
          model(d, a, w, wd, erd, eer);
          chk($sformatf("rnd%0d_%0d_ready", d, n), {31'b0, done}, 32'h1);
          chk($sformatf("rnd%0d_%0d_waits a=%h", d, n, a), low, waits);
          chk($sformatf("rnd%0d_%0d_err a=%h", d, n, a), {31'b0, er}, {31'b0, eer});
          chk($sformatf("rnd%0d_%0d_rdata a=%h", d, n, a), rd, erd);
        end
        if ($urandom_range(0, 3) == 0) idle(d);
      end
      idle(d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
